// File: rtl/fp_issue_pkg.sv
// rtl/fp_issue_pkg.sv - shared constants for the FP unit issue controller
//
// Contents:
//   ST_*          FSM state encoding (IDLE / ISSUE / WB)
//   OP_*          op_sel codes presented by the execute stage
//   NUM_UNITS     number of multi-cycle FP units (add, mul, div)
//   ERR_*         bit positions inside the sticky err vector
//   unit_onehot   op_sel -> one-hot unit enable (illegal code maps to none)
//   cnt_width     width of the issue-cycle counter for a given timeout

package fp_issue_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WB    = 2'd2;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_MUL = 2'd1;
    localparam logic [1:0] OP_DIV = 2'd2;
    localparam logic [1:0] OP_ILL = 2'd3;

    localparam int NUM_UNITS = 3;

    localparam int ERR_TIMEOUT = 0;
    localparam int ERR_ILLEGAL = 1;

    function automatic logic [NUM_UNITS-1:0] unit_onehot(input logic [1:0] sel);
        logic [NUM_UNITS-1:0] oh;
        oh = '0;
        case (sel)
            OP_ADD:  oh = 3'b001;
            OP_MUL:  oh = 3'b010;
            OP_DIV:  oh = 3'b100;
            default: oh = '0;
        endcase
        return oh;
    endfunction

    // A zero timeout still needs a one-bit counter.
    function automatic int cnt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/fp_issue_timer.sv
// rtl/fp_issue_timer.sv - saturating issue-cycle counter with expiry flag
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        synchronous clear to 0 (takes priority over enable)
//   enable       count up by one, saturating at TIMEOUT
//   cnt          current count
//   expired      cnt has reached TIMEOUT

module fp_issue_timer
    import fp_issue_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = cnt_width(TIMEOUT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] cnt,
    output logic             expired
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt     = cnt_q;
    assign expired = (cnt_q == CNT_MAX);

endmodule

// File: rtl/fp_issue_ctrl.sv
// rtl/fp_issue_ctrl.sv - issue/stall/writeback controller for multi-cycle FP units
//
// Accepts one FP op at a time from the execute stage, enables the selected
// unit until it drops stall, then presents a single-cycle register writeback.
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   op_valid/op_ready   op handshake from the CPU (ready only while idle)
//   op_sel              0 add, 1 mul, 2 div, 3 illegal
//   op_a, op_b, op_rd   operands and destination register
//   busy                pipeline stall while an op is in flight
//   unit_en             one-hot enable to the add/mul/div units
//   unit_a, unit_b      latched operands, shared by all units
//   unit_q              unit results, slice i belongs to unit i
//   unit_stall          per-unit stall
//   wb_valid            one-cycle writeback strobe
//   wb_rd, wb_data      writeback register index and value
//   err_clr             clears the sticky error flags
//   err                 sticky flags: bit0 timeout, bit1 illegal op

module fp_issue_ctrl
    import fp_issue_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int RD_W    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        op_valid,
    output logic                        op_ready,
    input  logic [1:0]                  op_sel,
    input  logic [DATA_W-1:0]           op_a,
    input  logic [DATA_W-1:0]           op_b,
    input  logic [RD_W-1:0]             op_rd,
    output logic                        busy,
    output logic [NUM_UNITS-1:0]        unit_en,
    output logic [DATA_W-1:0]           unit_a,
    output logic [DATA_W-1:0]           unit_b,
    input  logic [NUM_UNITS*DATA_W-1:0] unit_q,
    input  logic [NUM_UNITS-1:0]        unit_stall,
    output logic                        wb_valid,
    output logic [RD_W-1:0]             wb_rd,
    output logic [DATA_W-1:0]           wb_data,
    input  logic                        err_clr,
    output logic [1:0]                  err
);

    localparam int CNT_W = cnt_width(TIMEOUT);

    logic [1:0]        state_q,   state_d;
    logic [1:0]        sel_q,     sel_d;
    logic [DATA_W-1:0] a_q,       a_d;
    logic [DATA_W-1:0] b_q,       b_d;
    logic [RD_W-1:0]   rd_q,      rd_d;
    logic [RD_W-1:0]   wb_rd_q,   wb_rd_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic [1:0]        err_q,     err_d;

    logic              tmr_clear;
    logic              tmr_enable;
    logic [CNT_W-1:0]  tmr_cnt;
    logic              tmr_expired;

    logic              sel_stall;
    logic [DATA_W-1:0] sel_result;
    logic              complete;
    logic [1:0]        err_set;

    fp_issue_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst_n   (reset),
        .clear   (tmr_clear),
        .enable  (tmr_enable),
        .cnt     (tmr_cnt),
        .expired (tmr_expired)
    );

    // Only the selected unit's stall and result matter; the rest are ignored.
    always_comb begin
        sel_stall  = 1'b1;
        sel_result = '0;
        case (sel_q)
            OP_ADD: begin
                sel_stall  = unit_stall[0];
                sel_result = unit_q[DATA_W-1:0];
            end
            OP_MUL: begin
                sel_stall  = unit_stall[1];
                sel_result = unit_q[2*DATA_W-1:DATA_W];
            end
            OP_DIV: begin
                sel_stall  = unit_stall[2];
                sel_result = unit_q[3*DATA_W-1:2*DATA_W];
            end
            default: begin
                sel_stall  = 1'b1;
                sel_result = '0;
            end
        endcase
    end

    // The unit sees its enable for the first time in the cnt == 0 cycle and
    // may still be showing a stale stall level, so that cycle never completes.
    assign complete = (tmr_cnt != '0) && !sel_stall;

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        a_d        = a_q;
        b_d        = b_q;
        rd_d       = rd_q;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        err_set    = 2'b00;
        tmr_clear  = 1'b0;
        tmr_enable = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (op_valid) begin
                    sel_d     = op_sel;
                    a_d       = op_a;
                    b_d       = op_b;
                    rd_d      = op_rd;
                    tmr_clear = 1'b1;
                    if (op_sel == OP_ILL) begin
                        err_set[ERR_ILLEGAL] = 1'b1;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                tmr_enable = 1'b1;
                // Completion is checked first so it wins over a same-cycle timeout.
                if (complete) begin
                    wb_data_d = sel_result;
                    wb_rd_d   = rd_q;
                    state_d   = ST_WB;
                end else if (tmr_expired) begin
                    err_set[ERR_TIMEOUT] = 1'b1;
                    state_d              = ST_IDLE;
                end
            end
            ST_WB: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new error event in the same cycle as err_clr stays set.
        err_d = (err_clr ? 2'b00 : err_q) | err_set;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            sel_q     <= OP_ADD;
            a_q       <= '0;
            b_q       <= '0;
            rd_q      <= '0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
            err_q     <= 2'b00;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            a_q       <= a_d;
            b_q       <= b_d;
            rd_q      <= rd_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
            err_q     <= err_d;
        end
    end

    // Enables and strobes decode straight from the state flop so an
    // asynchronous reset drops them immediately.
    assign op_ready = (state_q == ST_IDLE);
    assign busy     = (state_q != ST_IDLE);
    assign unit_en  = (state_q == ST_ISSUE) ? unit_onehot(sel_q) : '0;
    assign unit_a   = a_q;
    assign unit_b   = b_q;
    assign wb_valid = (state_q == ST_WB);
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;
    assign err      = err_q;

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// tb/tb_fp_issue_ctrl.sv - self-checking bench for fp_issue_ctrl

module tb_fp_issue_ctrl;

    localparam int DATA_W  = 16;
    localparam int RD_W    = 4;
    localparam int TIMEOUT = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          op_valid;
    logic          op_ready;
    logic [1:0]    op_sel;
    logic [15:0]   op_a, op_b;
    logic [3:0]    op_rd;
    logic          busy;
    logic [2:0]    unit_en;
    logic [15:0]   unit_a, unit_b;
    logic [47:0]   unit_q;
    logic [2:0]    unit_stall;
    logic          wb_valid;
    logic [3:0]    wb_rd;
    logic [15:0]   wb_data;
    logic          err_clr;
    logic [1:0]    err;

    int            n_cmp  = 0;
    int            n_fail = 0;
    logic [1:0]    err_m  = 2'b00;

    fp_issue_ctrl #(
        .DATA_W  (DATA_W),
        .RD_W    (RD_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_sel     (op_sel),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_rd      (op_rd),
        .busy       (busy),
        .unit_en    (unit_en),
        .unit_a     (unit_a),
        .unit_b     (unit_b),
        .unit_q     (unit_q),
        .unit_stall (unit_stall),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .err_clr    (err_clr),
        .err        (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Unit model: the selected unit shows the requested stall and result,
    // every other unit shows random noise that the controller must ignore.
    task automatic drive_units(input logic [1:0] sel, input logic sel_stall, input logic [15:0] q);
        logic [15:0] qs [3];
        for (int u = 0; u < 3; u++) qs[u] = 16'($urandom);
        unit_stall = 3'($urandom);
        if (sel < 2'd3) begin
            qs[sel]         = q;
            unit_stall[sel] = sel_stall;
        end
        unit_q = {qs[2], qs[1], qs[0]};
    endtask

    // mask bit i is the selected unit's stall during enable cycle i (cnt == i).
    // Expected behaviour is derived from the op rules: first stall-low cycle
    // with cnt >= 1 completes, none within TIMEOUT means a timeout.
    task automatic run_op(input string name, input logic [1:0] sel,
                          input logic [15:0] a, input logic [15:0] b, input logic [15:0] q,
                          input logic [3:0] rd, input logic [31:0] mask, input bit clr,
                          input bit keep, input logic [1:0] psel, input logic [15:0] pa,
                          input logic [15:0] pb, input logic [3:0] prd);
        int         k;
        int         n_en;
        int         last;
        bit         ill;
        bit         tmo;
        bit         wb_now;
        logic       stall_now;
        logic [2:0] oh;
        logic [1:0] err_pre;
        logic [1:0] err_exp;

        ill = (sel == 2'd3);
        k   = 0;
        for (int i = 1; i <= TIMEOUT; i++) begin
            if (k == 0 && !mask[i]) k = i;
        end
        tmo     = !ill && (k == 0);
        n_en    = ill ? 0 : (tmo ? TIMEOUT + 1 : k + 1);
        last    = ill ? 1 : (tmo ? TIMEOUT + 2 : k + 3);
        oh      = ill ? 3'b000 : 3'(1 << sel);
        err_pre = clr ? 2'b00 : err_m;
        err_exp = err_pre;

        op_valid = 1'b1;
        op_sel   = sel;
        op_a     = a;
        op_b     = b;
        op_rd    = rd;
        err_clr  = clr;
        drive_units(sel, 1'b1, q);
        tick();
        err_clr = 1'b0;
        if (keep) begin
            op_sel = psel;
            op_a   = pa;
            op_b   = pb;
            op_rd  = prd;
        end else begin
            op_valid = 1'b0;
        end

        for (int c = 1; c <= last; c++) begin
            stall_now = (c - 1 < 32) ? mask[5'(c - 1)] : 1'b1;
            drive_units(sel, stall_now, q);
            wb_now  = !ill && !tmo && (c == k + 2);
            err_exp = err_pre | (ill ? 2'b10 : 2'b00) | ((tmo && c >= TIMEOUT + 2) ? 2'b01 : 2'b00);
            check({name, " unit_en"},  64'(unit_en),  64'((c <= n_en) ? oh : 3'b000));
            check({name, " wb_valid"}, 64'(wb_valid), 64'(wb_now));
            check({name, " op_ready"}, 64'(op_ready), 64'(c >= last));
            check({name, " busy"},     64'(busy),     64'(c < last));
            check({name, " err"},      64'(err),      64'(err_exp));
            if (c <= n_en) begin
                check({name, " operands"}, 64'({unit_a, unit_b}), 64'({a, b}));
            end
            if (wb_now) begin
                check({name, " wb_rd"},   64'(wb_rd),   64'(rd));
                check({name, " wb_data"}, 64'(wb_data), 64'(q));
            end
            if (c < last) tick();
        end
        err_m = err_exp;
    endtask

    task automatic clear_err(input string name);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        err_m   = 2'b00;
        check({name, " err after clr"}, 64'(err), 64'(2'b00));
    endtask

    initial begin
        logic [1:0]  r_sel;
        logic [31:0] r_mask;
        int          r_k;

        reset      = 1'b0;
        op_valid   = 1'b0;
        op_sel     = 2'd0;
        op_a       = '0;
        op_b       = '0;
        op_rd      = '0;
        unit_q     = '0;
        unit_stall = '0;
        err_clr    = 1'b0;

        tick();
        tick();
        check("reset op_ready", 64'(op_ready), 64'(1'b1));
        check("reset busy",     64'(busy),     64'(1'b0));
        check("reset unit_en",  64'(unit_en),  64'(3'b000));
        check("reset wb_valid", 64'(wb_valid), 64'(1'b0));
        check("reset wb",       64'({wb_rd, wb_data}), 64'(20'h0));
        check("reset err",      64'(err),      64'(2'b00));
        check("reset operands", 64'({unit_a, unit_b}), 64'(32'h0));
        reset = 1'b1;
        tick();

        // div, stall held for cnt 0..5, done at cnt 6: seven enable cycles
        run_op("div", 2'd2, 16'h4400, 16'h4000, 16'h4000, 4'd5, 32'hFFFF_FFBF, 1'b0,
               1'b0, 2'd0, 16'h0, 16'h0, 4'd0);
        // stall low at cnt 0 must be ignored, completion at cnt 3
        run_op("guard", 2'd0, 16'h3C00, 16'h3C00, 16'h4000, 4'd3, 32'hFFFF_FFF6, 1'b0,
               1'b0, 2'd0, 16'h0, 16'h0, 4'd0);
        // shortest completion
        run_op("min", 2'd1, 16'h1234, 16'h5678, 16'h9ABC, 4'd9, 32'hFFFF_FFFD, 1'b0,
               1'b0, 2'd0, 16'h0, 16'h0, 4'd0);
        // completion on the last allowed count beats the timeout
        run_op("late", 2'd2, 16'h0101, 16'h0202, 16'hBEEF, 4'd1, 32'hFFFF_7FFF, 1'b0,
               1'b0, 2'd0, 16'h0, 16'h0, 4'd0);
        // mul stuck in stall
        run_op("timeout", 2'd1, 16'hAAAA, 16'h5555, 16'h0000, 4'd7, 32'hFFFF_FFFF, 1'b0,
               1'b0, 2'd0, 16'h0, 16'h0, 4'd0);
        clear_err("timeout");
        run_op("illegal", 2'd3, 16'h1111, 16'h2222, 16'h3333, 4'd2, 32'hFFFF_FFFF, 1'b0,
               1'b0, 2'd0, 16'h0, 16'h0, 4'd0);
        clear_err("illegal");
        // illegal op with err_clr in the same edge: timeout bit clears, illegal bit sets
        run_op("timeout2", 2'd0, 16'h0F0F, 16'hF0F0, 16'h0000, 4'd8, 32'hFFFF_FFFF, 1'b0,
               1'b0, 2'd0, 16'h0, 16'h0, 4'd0);
        run_op("ill+clr", 2'd3, 16'h0001, 16'h0002, 16'h0003, 4'd4, 32'hFFFF_FFFF, 1'b1,
               1'b0, 2'd0, 16'h0, 16'h0, 4'd0);
        clear_err("ill+clr");

        // op_valid held: div fields presented while the add is in flight
        run_op("b2b add", 2'd0, 16'h3C00, 16'h4000, 16'h4200, 4'd6, 32'hFFFF_FFF9, 1'b0,
               1'b1, 2'd2, 16'h4800, 16'h4000, 4'd11);
        run_op("b2b div", 2'd2, 16'h4800, 16'h4000, 16'h4400, 4'd11, 32'hFFFF_FFF7, 1'b0,
               1'b0, 2'd0, 16'h0, 16'h0, 4'd0);

        for (int n = 0; n < 25; n++) begin
            r_sel  = 2'($urandom_range(0, 3));
            r_k    = $urandom_range(1, 18);
            r_mask = $urandom;
            for (int i = 1; i < r_k && i < 32; i++) r_mask[i] = 1'b1;
            if (r_k <= TIMEOUT) r_mask[r_k] = 1'b0;
            run_op("rand", r_sel, 16'($urandom), 16'($urandom), 16'($urandom),
                   4'($urandom), r_mask, ($urandom_range(0, 3) == 0),
                   1'b0, 2'd0, 16'h0, 16'h0, 4'd0);
        end

        // leave a sticky error and a nonzero writeback behind, then reset mid-div
        run_op("pre-rst", 2'd3, 16'h0, 16'h0, 16'h0, 4'd0, 32'hFFFF_FFFF, 1'b0,
               1'b0, 2'd0, 16'h0, 16'h0, 4'd0);
        run_op("pre-rst2", 2'd1, 16'h1, 16'h2, 16'hCAFE, 4'd12, 32'hFFFF_FFFD, 1'b0,
               1'b0, 2'd0, 16'h0, 16'h0, 4'd0);
        op_valid = 1'b1;
        op_sel   = 2'd2;
        op_a     = 16'h4400;
        op_b     = 16'h4000;
        op_rd    = 4'd5;
        drive_units(2'd2, 1'b1, 16'h4000);
        tick();
        op_valid = 1'b0;
        drive_units(2'd2, 1'b1, 16'h4000);
        tick();
        tick();
        check("mid-op unit_en", 64'(unit_en), 64'(3'b100));
        #1 reset = 1'b0;
        #1;
        check("async rst unit_en",  64'(unit_en),  64'(3'b000));
        check("async rst wb_valid", 64'(wb_valid), 64'(1'b0));
        tick();
        reset = 1'b1;
        err_m = 2'b00;
        tick();
        check("post rst op_ready", 64'(op_ready), 64'(1'b1));
        check("post rst busy",     64'(busy),     64'(1'b0));
        check("post rst err",      64'(err),      64'(2'b00));
        check("post rst wb_data",  64'(wb_data),  64'(16'h0000));
        check("post rst wb_valid", 64'(wb_valid), 64'(1'b0));

        run_op("after rst", 2'd0, 16'h3C00, 16'h3C00, 16'h4000, 4'd2, 32'hFFFF_FFF3, 1'b0,
               1'b0, 2'd0, 16'h0, 16'h0, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_issue_ctrl.md
# fp_issue_ctrl

Initiator side of the enable/stall handshake used by the multi-cycle floating-point units (add, mul, div). The CPU execute stage hands one FP operation to this block. The block then:
- latches the operands and destination register;
- holds the selected unit's enable until that unit drops stall;
- captures the 16-bit result and presents a one-cycle register writeback.

It also holds the pipeline busy and flags hung units (timeout) and illegal op selects.

## Interface
Parameters:
- DATA_W, 16, FP operand/result width (half precision)
- RD_W, 4, destination register index width
- TIMEOUT, 15, last ISSUE count value allowed before abort

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = in reset)
- op_valid  in  1  CPU presents an FP op
- op_ready  out  1  block can accept (high only in IDLE)
- op_sel  in  2  0 add, 1 mul, 2 div, 3 illegal
- op_a, op_b  in  DATA_W  operands
- op_rd  in  RD_W  destination register
- busy  out  1  state != IDLE (CPU stall)
- unit_en  out  3  one-hot enable to add/mul/div units
- unit_a, unit_b  out  DATA_W  shared operand bus to all units
- unit_q  in  3*DATA_W  results; slice i = unit i
- unit_stall  in  3  stall from each unit
- wb_valid  out  1  writeback strobe, one cycle
- wb_rd  out  RD_W  writeback register
- wb_data  out  DATA_W  writeback value
- err_clr  in  1  clears sticky error flags
- err  out  2  sticky: bit0 timeout, bit1 illegal op

## Operation
- States: IDLE, ISSUE, WB.
- IDLE:
  - op_ready = 1.
  - On op_valid at an edge: latch op_a, op_b, op_rd, op_sel; clear cnt.
  - op_sel 0-2 → ISSUE.
  - op_sel 3 → stay in IDLE, set err[1]; no unit enabled.
- ISSUE:
  - unit_en[sel] = 1; every other unit_en bit is 0.
  - unit_a/unit_b driven from the latched registers, stable for the whole state.
  - cnt increments every cycle, saturating at TIMEOUT.
  - Completion: unit_stall[sel] == 0 while cnt >= 1. The first enable cycle (cnt == 0) is never a completion, whatever stall shows.
  - On completion: wb_data <= unit_q slice [sel], wb_rd <= latched rd, go to WB.
  - Timeout: cnt == TIMEOUT and no completion → IDLE, set err[0], no writeback.
  - Completion and timeout in the same cycle → completion wins.
- WB:
  - wb_valid = 1 for exactly one cycle; unit_en = 0.
  - Next state IDLE.
- busy = (state != IDLE).
- unit_stall bits of unselected units are ignored.
- Error flags:
  - err bits stay set until err_clr = 1 at an edge; err_clr then clears both bits.
  - If a set event and err_clr coincide, the set wins.
- cnt width: clog2(TIMEOUT+1).

## Timing
- Reset values:
  - state IDLE, op_ready 1, busy 0, unit_en 0, wb_valid 0;
  - wb_rd 0, wb_data 0, err 0, cnt 0, operand registers 0.
- Reset mid-operation: unit_en and wb_valid drop asynchronously; no writeback; the op is lost.
- Accept at edge T:
  - unit_en high from T+1.
  - Unit drops stall in the cycle at cnt = k (k >= 1) → WB from T+k+2, wb_valid in that cycle.
  - op_ready returns at T+k+3.
- Enable-high duration is k+1 cycles.
- Minimum completion (stall low at cnt = 1): unit_en high 2 cycles, wb_valid at T+3.
- Timeout: unit_en high exactly TIMEOUT+1 cycles, then IDLE.
- Illegal op: op_ready stays 1; err[1] visible from T+1.
- Throughput: one op per k+3 cycles; no overlap between ops.

## Structure
- Package fp_issue_pkg holds:
  - state encoding (IDLE/ISSUE/WB);
  - op_sel codes (OP_ADD, OP_MUL, OP_DIV, OP_ILL);
  - NUM_UNITS = 3;
  - error bit indices.
- One sub-module, fp_issue_timer: owns the saturating cnt, with clear/enable inputs and an expired output.
- FSM, operand latches and writeback registers stay in fp_issue_ctrl.

## Test plan
- Reset: pull reset low during ISSUE (div) → unit_en = 0 and wb_valid = 0 immediately. After release: op_ready = 1, err = 0, wb_data = 0x0000.
- Div: sel=2, a=0x4400, b=0x4000, rd=5; unit model holds stall for 6 cycles, q=0x4000 → unit_en = 3'b100 for exactly 7 cycles, then one wb_valid with wb_rd=5, wb_data=0x4000.
- First-cycle guard: sel=0, a=0x3C00, b=0x3C00; model stall = 0 at cnt 0, 1 at cnt 1-2, 0 at cnt 3, q=0x4000 → single completion at cnt 3, wb_data=0x4000, never at cnt 0.
- Timeout: TIMEOUT=15, mul unit stall stuck high → unit_en[1] high 16 cycles, err = 2'b01, no wb_valid. err_clr pulse → err = 2'b00.
- Illegal: sel=3 → unit_en stays 0, err = 2'b10, op_ready never drops, no wb_valid.
- Back-to-back: op_valid held with an add then a div → second op accepted only on the first IDLE edge after WB. wb_rd/wb_data are correct for both ops, in order.
